// File: rtl/pc_update_sequencer_if.sv
// Handshake and control bundle between the main control unit and the PC-update sequencer.
// The master is the control unit; the slave is the sequencer.
interface pc_update_sequencer_if;
  logic        reqValid;
  logic [2:0]  pcOp;
  logic        branchCond;
  logic        excOpcode;
  logic        excOverflow;
  logic        excDivZero;
  logic        ready;
  logic [2:0]  muxpcsource;
  logic        pcWrite;
  logic        epcWrite;
  logic        memRead;
  logic [31:0] excVecAddr;
  logic [1:0]  excCause;
  logic        done;

  modport master (
    output reqValid, pcOp, branchCond, excOpcode, excOverflow, excDivZero,
    input  ready, muxpcsource, pcWrite, epcWrite, memRead, excVecAddr, excCause, done
  );

  modport slave (
    input  reqValid, pcOp, branchCond, excOpcode, excOverflow, excDivZero,
    output ready, muxpcsource, pcWrite, epcWrite, memRead, excVecAddr, excCause, done
  );
endinterface

// File: rtl/pc_update_sequencer.sv
// Multicycle PC-update controller: sequences PC-source select and PC write for normal
// updates, and the EPC save / vector fetch / PC load sequence for exceptions.
module pc_update_sequencer #(
  parameter int unsigned MEM_LAT    = 2,
  parameter logic [31:0] VEC_OPCODE = 32'd253,
  parameter logic [31:0] VEC_OVF    = 32'd254,
  parameter logic [31:0] VEC_DIV0   = 32'd255
) (
  input  logic               clk,
  input  logic               reset,
  pc_update_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, EXEC, EXC_SAVE, EXC_READ, EXC_LOAD} state_e;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_OPCODE, CAUSE_OVF, CAUSE_DIV0} cause_e;

  localparam logic [2:0] OP_NEXT   = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_RTE    = 3'd3;
  localparam logic [2:0] OP_JR     = 3'd4;

  localparam logic [2:0] SRC_ALU  = 3'd0;
  localparam logic [2:0] SRC_S    = 3'd1;
  localparam logic [2:0] SRC_JUMP = 3'd2;
  localparam logic [2:0] SRC_EPC  = 3'd3;
  localparam logic [2:0] SRC_MDR  = 3'd4;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  function automatic logic [2:0] pc_source(input logic [2:0] op);
    case (op)
      OP_NEXT:          return SRC_ALU;
      OP_BRANCH, OP_JR: return SRC_S;
      OP_JUMP:          return SRC_JUMP;
      OP_RTE:           return SRC_EPC;
      default:          return SRC_ALU;
    endcase
  endfunction

  function automatic logic [31:0] vector_of(input cause_e c);
    case (c)
      CAUSE_OPCODE: return VEC_OPCODE;
      CAUSE_OVF:    return VEC_OVF;
      CAUSE_DIV0:   return VEC_DIV0;
      default:      return 32'd0;
    endcase
  endfunction

  state_e      state_q;
  cause_e      cause_q;
  cause_e      cause_d;
  logic [2:0]  cnt_q;
  logic        ready_q;
  logic [2:0]  mux_q;
  logic        pc_write_q;
  logic        epc_write_q;
  logic        mem_read_q;
  logic [31:0] vec_q;
  logic        done_q;
  logic        illegal_op;

  assign illegal_op = bus.reqValid && (bus.pcOp > OP_JR);

  // Exception cause priority: illegal op / opcode > overflow > divide-by-zero.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves cause_d unassigned (no latch).
    cause_d = CAUSE_NONE;
    if (illegal_op || bus.excOpcode) cause_d = CAUSE_OPCODE;
    else if (bus.excOverflow)        cause_d = CAUSE_OVF;
    else if (bus.excDivZero)         cause_d = CAUSE_DIV0;
  end

  // Outputs are registered with the value they must show in the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cause_q     <= CAUSE_NONE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      mux_q       <= SRC_ALU;
      pc_write_q  <= 1'b0;
      epc_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      vec_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so later defaults/overrides in this block
      // resolve by last-write-wins without creating ordering hazards between registers.
      ready_q     <= 1'b0;
      mux_q       <= SRC_ALU;
      pc_write_q  <= 1'b0;
      epc_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      vec_q       <= '0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cause_d != CAUSE_NONE) begin
            cause_q     <= cause_d;
            state_q     <= EXC_SAVE;
            epc_write_q <= 1'b1;
          end else if (bus.reqValid) begin
            state_q    <= EXEC;
            mux_q      <= pc_source(bus.pcOp);
            pc_write_q <= (bus.pcOp == OP_BRANCH) ? bus.branchCond : 1'b1;
            done_q     <= 1'b1;
          end else begin
            ready_q <= 1'b1;
          end
        end
        EXEC, EXC_LOAD: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        EXC_SAVE: begin
          state_q    <= EXC_READ;
          cnt_q      <= CNT_INIT;
          mem_read_q <= 1'b1;
          vec_q      <= vector_of(cause_q);
        end
        EXC_READ: begin
          if (cnt_q == 3'd0) begin
            state_q    <= EXC_LOAD;
            mux_q      <= SRC_MDR;
            pc_write_q <= 1'b1;
            done_q     <= 1'b1;
          end else begin
            cnt_q      <= cnt_q - 3'd1;
            mem_read_q <= 1'b1;
            vec_q      <= vector_of(cause_q);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready       = ready_q;
  assign bus.muxpcsource = mux_q;
  assign bus.pcWrite     = pc_write_q;
  assign bus.epcWrite    = epc_write_q;
  assign bus.memRead     = mem_read_q;
  assign bus.excVecAddr  = vec_q;
  assign bus.excCause    = cause_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_pc_update_sequencer.sv
// Directed scoreboard bench for pc_update_sequencer: two instances (MEM_LAT 2 and 4)
// share clock and reset; expected per-cycle outputs are queued at drive time and popped per cycle.
module tb_pc_update_sequencer;

  typedef struct packed {
    logic        ready;
    logic [2:0]  mux;
    logic        pcw;
    logic        epcw;
    logic        memrd;
    logic [31:0] vec;
    logic [1:0]  cause;
    logic        done;
  } out_t;

  logic clk = 1'b0;
  logic reset;

  pc_update_sequencer_if bus2();
  pc_update_sequencer_if bus4();

  pc_update_sequencer #(.MEM_LAT(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
  pc_update_sequencer #(.MEM_LAT(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  out_t sb[$];
  logic [1:0] cur_cause [2];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic out_t idle_o(input logic [1:0] c);
    out_t o = '0;
    o.ready = 1'b1;
    o.cause = c;
    return o;
  endfunction

  function automatic logic [31:0] vec_of(input logic [1:0] c);
    case (c)
      2'd1:    return 32'd253;
      2'd2:    return 32'd254;
      2'd3:    return 32'd255;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [2:0] src_of(input logic [2:0] op);
    case (op)
      3'd1, 3'd4: return 3'd1;
      3'd2:       return 3'd2;
      3'd3:       return 3'd3;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic out_t obs(input bit sel);
    out_t o;
    if (!sel) o = {bus2.ready, bus2.muxpcsource, bus2.pcWrite, bus2.epcWrite, bus2.memRead,
                   bus2.excVecAddr, bus2.excCause, bus2.done};
    else      o = {bus4.ready, bus4.muxpcsource, bus4.pcWrite, bus4.epcWrite, bus4.memRead,
                   bus4.excVecAddr, bus4.excCause, bus4.done};
    return o;
  endfunction

  task automatic check(input string tag, input out_t got, input out_t exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rv, input logic [2:0] op, input logic bc,
                       input logic eo, input logic ev, input logic ed);
    if (!sel) begin
      bus2.reqValid = rv; bus2.pcOp = op; bus2.branchCond = bc;
      bus2.excOpcode = eo; bus2.excOverflow = ev; bus2.excDivZero = ed;
    end else begin
      bus4.reqValid = rv; bus4.pcOp = op; bus4.branchCond = bc;
      bus4.excOpcode = eo; bus4.excOverflow = ev; bus4.excDivZero = ed;
    end
  endtask

  task automatic push_req(input bit sel, input logic [2:0] op, input logic bc);
    out_t o = '0;
    o.mux   = src_of(op);
    o.pcw   = (op == 3'd1) ? bc : 1'b1;
    o.done  = 1'b1;
    o.cause = cur_cause[sel];
    sb.push_back(o);
    sb.push_back(idle_o(cur_cause[sel]));
  endtask

  task automatic push_exc(input bit sel, input logic [1:0] c, input int lat);
    out_t o;
    cur_cause[sel] = c;
    o = '0; o.epcw = 1'b1; o.cause = c;
    sb.push_back(o);
    for (int i = 0; i < lat; i++) begin
      o = '0; o.memrd = 1'b1; o.vec = vec_of(c); o.cause = c;
      sb.push_back(o);
    end
    o = '0; o.mux = 3'd4; o.pcw = 1'b1; o.done = 1'b1; o.cause = c;
    sb.push_back(o);
    sb.push_back(idle_o(c));
  endtask

  // Called at #1 after an edge; the first queued entry belongs to the current cycle.
  task automatic run_sb(input bit sel, input string tag);
    out_t e;
    int   k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("%s[%0d]", tag, k), obs(sel), e);
      k++;
      if (sb.size() > 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic issue(input bit sel, input string tag, input logic rv, input logic [2:0] op,
                       input logic bc, input logic eo, input logic ev, input logic ed);
    logic [1:0] c = 2'd0;
    if ((rv && op > 3'd4) || eo) c = 2'd1;
    else if (ev)                 c = 2'd2;
    else if (ed)                 c = 2'd3;
    if (c != 2'd0)  push_exc(sel, c, sel ? 4 : 2);
    else if (rv)    push_req(sel, op, bc);
    else            sb.push_back(idle_o(cur_cause[sel]));
    drive(sel, rv, op, bc, eo, ev, ed);
    @(posedge clk); #1;
    drive(sel, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_sb(sel, tag);
  endtask

  initial begin
    cur_cause[0] = 2'd0;
    cur_cause[1] = 2'd0;
    reset = 1'b0;
    drive(0, 0, 3'd0, 0, 0, 0, 0);
    drive(1, 0, 3'd0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_dut2", obs(0), idle_o(2'd0));
    check("reset_dut4", obs(1), idle_o(2'd0));
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", obs(0), idle_o(2'd0));

    issue(0, "idle",      0, 3'd0, 0, 0, 0, 0);
    issue(0, "next",      1, 3'd0, 0, 0, 0, 0);
    issue(0, "br_taken",  1, 3'd1, 1, 0, 0, 0);
    issue(0, "br_not",    1, 3'd1, 0, 0, 0, 0);
    issue(0, "jump",      1, 3'd2, 0, 0, 0, 0);
    issue(0, "rte",       1, 3'd3, 0, 0, 0, 0);
    issue(0, "jr",        1, 3'd4, 1, 0, 0, 0);
    issue(0, "ovf",       0, 3'd0, 0, 0, 1, 0);
    issue(0, "div0_jump", 1, 3'd2, 0, 0, 0, 1);
    issue(0, "ovf_div0",  0, 3'd0, 0, 0, 1, 1);
    issue(0, "ill_op6",   1, 3'd6, 0, 0, 0, 0);
    issue(0, "opc_ovf",   0, 3'd0, 0, 1, 1, 0);
    issue(0, "next_again",1, 3'd0, 0, 0, 0, 0);

    // Opcode exception on the MEM_LAT=4 instance, reset during its 2nd EXC_READ cycle.
    push_exc(1, 2'd1, 4);
    while (sb.size() > 3) void'(sb.pop_back());
    drive(1, 0, 3'd0, 0, 1, 0, 0);
    @(posedge clk); #1;
    drive(1, 0, 3'd0, 0, 0, 0, 0);
    run_sb(1, "rst_seq");
    reset = 1'b0;
    @(posedge clk); #1;
    cur_cause[0] = 2'd0;
    cur_cause[1] = 2'd0;
    check("mid_read_reset_dut4", obs(1), idle_o(2'd0));
    check("mid_read_reset_dut2", obs(0), idle_o(2'd0));
    reset = 1'b1;
    @(posedge clk); #1;
    check("release_idle_dut4", obs(1), idle_o(2'd0));
    issue(1, "post_rst_next", 1, 3'd0, 0, 0, 0, 0);
    issue(1, "div0_lat4",     0, 3'd0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_update_sequencer.md
# pc_update_sequencer

Multicycle PC-update controller for the CPU datapath. Accepts one PC-update request per instruction from the main control unit, or an exception flag, and sequences the PC-source mux select, PC write enable, EPC write and exception-vector memory read. It drives the 3-bit PC-source select directly and is the only block allowed to assert PC write after fetch.

## Interface
Parameters:
- MEM_LAT, 2, memory read latency in cycles (1..7) between memRead assertion and valid MDR data.
- VEC_OPCODE, 32'd253, vector byte address for invalid-opcode exception.
- VEC_OVF, 32'd254, vector byte address for overflow exception.
- VEC_DIV0, 32'd255, vector byte address for divide-by-zero exception.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- reqValid  in  1  PC-update request valid.
- pcOp  in  3  request type: 0 NEXT, 1 BRANCH, 2 JUMP, 3 RTE, 4 JR; 5..7 illegal.
- branchCond  in  1  branch condition from ALU flags; sampled at accept.
- excOpcode, excOverflow, excDivZero  in  1 each  exception flags.
- ready  out  1  high only in IDLE; request/exception accepted when ready is high at the rising edge.
- muxpcsource  out  3  PC-source select: 0 ALU result, 1 S, 2 shifted jump target, 3 EPC, 4 MDR.
- pcWrite  out  1  PC write enable.
- epcWrite  out  1  EPC write enable.
- memRead  out  1  memory read strobe for the vector fetch.
- excVecAddr  out  32  vector address; valid while memRead high, otherwise 0.
- excCause  out  2  last exception: 0 none, 1 opcode, 2 overflow, 3 div0.
- done  out  1  one-cycle pulse in the cycle the PC is written, or the update is skipped.

## Operation
- All outputs are Moore, decoded from registered state and latched operation fields.
- States: IDLE, EXEC, EXC_SAVE, EXC_READ, EXC_LOAD.
- IDLE:
  - Exception pending (any exc flag, or reqValid with pcOp 5..7): latch cause and go to EXC_SAVE.
  - Cause priority: illegal pcOp / excOpcode > excOverflow > excDivZero.
  - Exceptions win over a simultaneous legal request; that request is dropped, and the control unit must not re-issue it.
  - Else reqValid: latch pcOp and branchCond, go to EXEC.
  - Else stay in IDLE.
- EXEC, one cycle, then IDLE:
  - muxpcsource = 0 for NEXT, 1 for BRANCH and JR, 2 for JUMP, 3 for RTE.
  - pcWrite = 1, except BRANCH, where pcWrite = latched branchCond.
  - done = 1.
- EXC_SAVE, one cycle: epcWrite = 1 (datapath presents PC-4 on the EPC input). Go to EXC_READ.
- EXC_READ:
  - memRead = 1; excVecAddr = vector for the latched cause.
  - 3-bit down-counter loaded with MEM_LAT-1 on entry; stay until the counter reaches 0, so EXC_READ lasts exactly MEM_LAT cycles.
  - Then go to EXC_LOAD.
- EXC_LOAD, one cycle, then IDLE: muxpcsource = 4, pcWrite = 1, done = 1.
- excCause is updated at exception accept and holds until the next exception or reset.
- Flags and requests arriving while ready is low are ignored (not queued). The control unit holds them until ready.

## Timing
- Reset (reset low at an edge) forces IDLE from any state, including mid EXC_READ. The counter is cleared and no pending write completes.
- Reset values: ready=1, muxpcsource=0, pcWrite=0, epcWrite=0, memRead=0, excVecAddr=0, excCause=0, done=0.
- Outside EXEC and EXC_LOAD: muxpcsource=0, pcWrite=0.
- Latency, accept edge to PC-write cycle:
  - Normal request: 1 cycle; ready returns high the following cycle, giving a throughput of one request per 2 cycles.
  - Exception: EXC_SAVE at +1, EXC_READ +2 .. +1+MEM_LAT, EXC_LOAD at +2+MEM_LAT.
- epcWrite and pcWrite are never high in the same cycle.
- memRead is high only in EXC_READ.
- Not-taken BRANCH: done=1 and pcWrite=0 in the EXEC cycle.

## Test plan
- Reset, then reqValid=1, pcOp=0 at edge 0 -> edge+1: muxpcsource=0, pcWrite=1, done=1, ready=0; edge+2: ready=1, pcWrite=0.
- BRANCH with branchCond=1, then BRANCH with branchCond=0 -> EXEC cycles show muxpcsource=1 with pcWrite=1, then muxpcsource=1 with pcWrite=0; done=1 both times.
- excOverflow=1 with MEM_LAT=2 -> epcWrite=1 at +1; memRead=1 with excVecAddr=254 at +2 and +3; muxpcsource=4, pcWrite=1, done=1 at +4; excCause=2.
- excDivZero=1 together with reqValid=1, pcOp=2 -> JUMP dropped; exception path taken with excVecAddr=255, excCause=3. Repeat with excOverflow+excDivZero -> excVecAddr=254.
- reqValid=1, pcOp=6 -> treated as opcode exception: excVecAddr=253, excCause=1, no EXEC cycle.
- Start excOpcode sequence with MEM_LAT=4; drop reset low during the 2nd EXC_READ cycle -> next cycle all outputs at reset values, no pcWrite; after release, a NEXT request completes in 1 cycle.
